// File: rtl/multu_seq_ctl_pkg.sv
// Shared definitions for the MULTU sequencer: decode codes, HiLo mux selects and FSM states.
package multu_seq_ctl_pkg;

   localparam logic [5:0] FunctMultu = 6'd25;
   localparam logic [5:0] FunctHi    = 6'd16;
   localparam logic [5:0] FunctLo    = 6'd18;

   localparam logic [1:0] AluOpMultu = 2'b11;

   localparam logic [1:0] HiLoSelHi  = 2'b01;
   localparam logic [1:0] HiLoSelLo  = 2'b10;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StLoad  = 2'd1,
      StRun   = 2'd2,
      StWrite = 2'd3
   } mul_state_e;

   function automatic logic is_multu(input logic [1:0] alu_op, input logic [5:0] funct);
      return (alu_op == AluOpMultu) || (funct == FunctMultu);
   endfunction

   function automatic logic is_hilo_rd(input logic [5:0] funct);
      return (funct == FunctHi) || (funct == FunctLo);
   endfunction

endpackage

// File: rtl/multu_seq_ctl_cnt.sv
// Step counter for the shift-add sequence: clear has priority over enable.
module mul_step_cnt
   import multu_seq_ctl_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             term
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign cnt  = cnt_q;
   assign term = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multu_seq_ctl.sv
// Sequencer for the iterative shift-add MULTU datapath and HiLo write, with decode stall.
module multu_seq_ctl
   import multu_seq_ctl_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             hilo_rd,
   input  logic             flush,
   input  logic             mplr_lsb,
   output logic             mul_load,
   output logic             mul_add,
   output logic             mul_shift,
   output logic             hilo_we,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic [CNT_W-1:0] step
);

   mul_state_e state_q, state_d;
   logic       step_clr, step_en, step_term;

   mul_step_cnt #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_step_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (step_clr),
      .en   (step_en),
      .cnt  (step),
      .term (step_term)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mul_load  = 1'b0;
      mul_add   = 1'b0;
      mul_shift = 1'b0;
      hilo_we   = 1'b0;
      done      = 1'b0;
      busy      = 1'b0;
      step_clr  = 1'b0;
      step_en   = 1'b0;
      unique case (state_q)
         StIdle: begin
            step_clr = 1'b1;
            if (start && !flush) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            mul_load = 1'b1;
            busy     = 1'b1;
            step_clr = 1'b1;
            state_d  = flush ? StIdle : StRun;
         end
         StRun: begin
            mul_shift = 1'b1;
            mul_add   = mplr_lsb;
            busy      = 1'b1;
            if (flush) begin
               step_clr = 1'b1;
               state_d  = StIdle;
            end else if (step_term) begin
               // Hold the last index through WRITE so step never reaches WIDTH.
               state_d  = StWrite;
            end else begin
               step_en  = 1'b1;
            end
         end
         StWrite: begin
            // The write is committed this cycle even if a flush arrives with it.
            hilo_we  = 1'b1;
            done     = 1'b1;
            busy     = 1'b1;
            step_clr = 1'b1;
            state_d  = (start && !flush) ? StLoad : StIdle;
         end
         default: begin
            state_d  = StIdle;
         end
      endcase
   end

   assign stall = busy & (hilo_rd | start);

endmodule

// File: tb/tb_multu_seq_ctl.sv
// Self-checking bench: timeline reference model plus a behavioural multiplier datapath.
module tb_multu_seq_ctl;

   localparam int W  = 32;
   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          hilo_rd = 1'b0;
   logic          flush = 1'b0;
   logic          mplr_lsb;
   logic          mul_load, mul_add, mul_shift, hilo_we, busy, done, stall;
   logic [CW-1:0] step;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multu_seq_ctl #(
      .WIDTH (W),
      .CNT_W (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .hilo_rd   (hilo_rd),
      .flush     (flush),
      .mplr_lsb  (mplr_lsb),
      .mul_load  (mul_load),
      .mul_add   (mul_add),
      .mul_shift (mul_shift),
      .hilo_we   (hilo_we),
      .busy      (busy),
      .done      (done),
      .stall     (stall),
      .step      (step)
   );

   // Behavioural shift-add datapath driven by the sequencer outputs
   logic [31:0] op_a = '0, op_b = '0;
   logic [31:0] mcand_q = '0, mplier_q = '0;
   logic [63:0] prod_q = '0, hilo_q = '0;

   assign mplr_lsb = mplier_q[0];

   function automatic logic [63:0] shift_step(input logic [63:0] p, input logic [31:0] mc,
                                              input logic add);
      logic [32:0] up;
      logic [64:0] full;
      up   = {1'b0, p[63:32]} + (add ? {1'b0, mc} : 33'd0);
      full = {up, p[31:0]};
      return full[64:1];
   endfunction

   always @(posedge clk) begin
      if (mul_load) begin
         mcand_q  <= op_a;
         mplier_q <= op_b;
         prod_q   <= '0;
      end else if (mul_shift) begin
         prod_q   <= shift_step(prod_q, mcand_q, mul_add);
         mplier_q <= mplier_q >> 1;
      end
      if (hilo_we) hilo_q <= prod_q;
   end

   // Reference model: k = cycles since the accepting edge (0 = idle).
   // k==1 load, 2..W+1 add/shift steps, W+2 HiLo write.
   int          k = 0;
   logic [31:0] m_a = '0, m_b = '0;
   logic [63:0] exp_hilo = '0;

   function automatic int next_k(input int kk, input logic r, input logic s, input logic f);
      if (r) return 0;
      if (kk == 0 || kk == W + 2) return (s && !f) ? 1 : 0;
      if (f) return 0;
      return kk + 1;
   endfunction

   always @(posedge clk) begin
      if (k == 1) begin
         m_a <= op_a;
         m_b <= op_b;
      end
      if (k == W + 2) exp_hilo <= {32'd0, m_a} * {32'd0, m_b};
      k <= next_k(k, rst, start, flush);
   end

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic run;
      int   idx;
      run = (k >= 2) && (k <= W + 1);
      idx = run ? k - 2 : 0;
      check1("busy", busy, k != 0);
      check1("mul_load", mul_load, k == 1);
      check1("mul_shift", mul_shift, run);
      check1("mul_add", mul_add, run && m_b[idx]);
      check1("hilo_we", hilo_we, k == W + 2);
      check1("done", done, k == W + 2);
      check1("stall", stall, (k != 0) && (hilo_rd || start));
      check64("step", 64'(step), run ? 64'(idx) : (k == W + 2) ? 64'(W - 1) : 64'd0);
      check64("hilo", hilo_q, exp_hilo);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_mult(input logic [31:0] a, input logic [31:0] b);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (35) tick();
   endtask

   initial begin
      int          nsh, nwe;
      logic [31:0] addpat;
      logic [63:0] saved;

      repeat (3) tick();
      rst = 1'b0;
      check1("rst_busy", busy, 1'b0);
      check1("rst_stall", stall, 1'b0);
      check64("rst_step", 64'(step), 64'd0);

      // Multiplier pattern A5A5A5A5 against multiplicand 1
      op_a  = 32'd1;
      op_b  = 32'hA5A5_A5A5;
      start = 1'b1;
      tick();
      start = 1'b0;
      nsh    = 0;
      addpat = '0;
      for (int c = 1; c <= 40; c++) begin
         check1("t1_load_cycle", mul_load, c == 1);
         check1("t1_we_cycle", hilo_we, c == 34);
         check1("t1_done_cycle", done, c == 34);
         if (mul_shift) begin
            if (nsh < 32) addpat[nsh] = mul_add;
            nsh++;
         end
         tick();
      end
      check64("t1_shift_count", 64'(nsh), 64'd32);
      check64("t1_add_pattern", 64'(addpat), 64'hA5A5_A5A5);
      check64("t1_hilo", hilo_q, 64'h0000_0000_A5A5_A5A5);

      run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check64("t2_hilo_max", hilo_q, 64'hFFFF_FFFE_0000_0001);
      run_mult(32'd3, 32'd5);
      check64("t2_hilo_3x5", hilo_q, 64'h0000_0000_0000_000F);

      // mfhi waiting in decode from cycle 5
      op_a  = 32'h0001_0000;
      op_b  = 32'h0001_0000;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 36; c++) begin
         hilo_rd = (c >= 5) && (c <= 35);
         #1;
         check1("t3_stall", stall, (c >= 5) && (c <= 34));
         if (c == 35) check64("t3_mfhi", 64'(hilo_q[63:32]), 64'd1);
         tick();
      end
      hilo_rd = 1'b0;

      // Back-to-back multu with start held
      start = 1'b1;
      tick();
      nwe = 0;
      for (int c = 1; c <= 70; c++) begin
         if (c == 35) start = 1'b0;
         #1;
         check1("t4_stall", stall, c <= 34);
         check1("t4_load", mul_load, (c == 1) || (c == 35));
         if (hilo_we) nwe++;
         tick();
      end
      check64("t4_we_count", 64'(nwe), 64'd2);

      // Flush at step 10, then reset at step 20
      saved = hilo_q;
      op_a  = 32'd11;
      op_b  = 32'd13;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (11) tick();
      check64("t5_step10", 64'(step), 64'd10);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check1("t5_flush_busy", busy, 1'b0);
      check64("t5_flush_step", 64'(step), 64'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (21) tick();
      check64("t5_step20", 64'(step), 64'd20);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check1("t5_rst_busy", busy, 1'b0);
      check64("t5_rst_step", 64'(step), 64'd0);
      nwe = 0;
      for (int c = 0; c < 40; c++) begin
         if (hilo_we) nwe++;
         tick();
      end
      check64("t5_no_write", 64'(nwe), 64'd0);
      check64("t5_hilo_kept", hilo_q, saved);
      run_mult(32'd7, 32'd9);
      check64("t5_restart", hilo_q, 64'd63);

      // start with flush in IDLE is rejected; mfhi while idle never stalls
      start = 1'b1;
      flush = 1'b1;
      tick();
      start = 1'b0;
      flush = 1'b0;
      check1("t6_busy", busy, 1'b0);
      check1("t6_load", mul_load, 1'b0);
      hilo_rd = 1'b1;
      #1;
      check1("t6_idle_stall", stall, 1'b0);
      tick();
      hilo_rd = 1'b0;

      // Randomised traffic against the model
      for (int c = 0; c < 4000; c++) begin
         start   = ($urandom % 6) == 0;
         hilo_rd = ($urandom % 4) == 0;
         flush   = ($urandom % 60) == 0;
         rst     = ($urandom % 500) == 0;
         op_a    = $urandom;
         op_b    = $urandom;
         tick();
      end
      start   = 1'b0;
      hilo_rd = 1'b0;
      flush   = 1'b0;
      rst     = 1'b0;
      repeat (40) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
